// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the interrupt controller.
// Provides the default datapath widths, the default interrupt vector
// location and the interrupt-service state encoding.
package cpu_pkg;

   localparam int unsigned CpuDataW = 16;
   localparam int unsigned CpuPcW   = 32;   // always 2 * CpuDataW
   localparam int unsigned CpuFlagW = 3;    // Z, N, C

   // Data-memory address of the vector high word; low word follows it.
   localparam logic [CpuPcW-1:0] CpuVectorAddr = '0;

   typedef enum logic [2:0] {
      StIdle      = 3'd0,
      StPushHi    = 3'd1,
      StPushLo    = 3'd2,
      StPushFlags = 3'd3,
      StVecHi     = 3'd4,
      StVecLo     = 3'd5,
      StJump      = 3'd6
   } int_state_e;

endpackage

// File: rtl/int_request_latch.sv
// Interrupt request latch: rising-edge detector on the external interrupt
// line plus a single pending bit. Repeated edges while pending merge.
//
// Ports:
//   i_clk     clock, rising edge
//   i_rst     synchronous active-high reset
//   i_int     external interrupt line
//   i_clear   drop the pending request (service is being started)
//   o_pending request outstanding; includes an edge seen this cycle so
//             service can start at the very next edge
module int_request_latch (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_int,
   input  logic i_clear,
   output logic o_pending
);

   logic int_prev_q;
   logic pending_q, pending_d;
   logic int_rise;

   assign int_rise  = i_int & ~int_prev_q;
   assign o_pending = pending_q | int_rise;

   // An edge arriving in the same cycle as the clear is the one being
   // serviced, so the clear wins.
   always_comb begin
      pending_d = o_pending;
      if (i_clear) begin
         pending_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         int_prev_q <= 1'b0;
         pending_q  <= 1'b0;
      end else begin
         int_prev_q <= i_int;
         pending_q  <= pending_d;
      end
   end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller for the pipelined CPU.
// Latches an external interrupt request, waits until the hazard unit no
// longer blocks interrupts, then runs a fixed six-cycle service sequence:
// push return PC (high, low) and flags onto the downward-growing data stack,
// read the two-word interrupt vector, and redirect the PC with a flush.
//
// Ports:
//   i_clk, i_rst         clock and synchronous active-high reset
//   i_int                external interrupt line (rising edge requests)
//   i_stall_interrupt    hazard unit blocks starting a service when high
//   i_pc, i_flags, i_sp  return address, CCR and stack pointer
//   i_mem_rdata          data memory read data (one cycle after request)
//   o_interrupt_call     high while servicing (to hazard unit)
//   o_stall_fetch        hold PC and F/D while servicing
//   o_mem_write/_read    data memory strobes
//   o_mem_addr/_wdata    data memory address and write data
//   o_sp_dec             decrement SP at the next edge
//   o_pc_load/_value     redirect PC to the vector target
//   o_flush              flush F/D and D/EM
module interrupt_controller
   import cpu_pkg::*;
#(
   parameter int unsigned      PC_W        = CpuPcW,
   parameter int unsigned      DATA_W      = CpuDataW,
   parameter int unsigned      FLAG_W      = CpuFlagW,
   parameter logic [PC_W-1:0]  VECTOR_ADDR = PC_W'(CpuVectorAddr)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_int,
   input  logic              i_stall_interrupt,
   input  logic [PC_W-1:0]   i_pc,
   input  logic [FLAG_W-1:0] i_flags,
   input  logic [PC_W-1:0]   i_sp,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic              o_interrupt_call,
   output logic              o_stall_fetch,
   output logic              o_mem_write,
   output logic              o_mem_read,
   output logic [PC_W-1:0]   o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic              o_sp_dec,
   output logic              o_pc_load,
   output logic [PC_W-1:0]   o_pc_value,
   output logic              o_flush
);

   int_state_e          state_q, state_d;
   logic [PC_W-1:0]     ret_q, ret_d;
   logic [FLAG_W-1:0]   flags_q, flags_d;
   logic [DATA_W-1:0]   vec_hi_q, vec_hi_d;
   logic                pending;
   logic                pend_clear;

   int_request_latch u_req (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_int     (i_int),
      .i_clear   (pend_clear),
      .o_pending (pending)
   );

   always_comb begin
      state_d    = state_q;
      ret_d      = ret_q;
      flags_d    = flags_q;
      vec_hi_d   = vec_hi_q;
      pend_clear = 1'b0;

      o_interrupt_call = 1'b0;
      o_stall_fetch    = 1'b0;
      o_mem_write      = 1'b0;
      o_mem_read       = 1'b0;
      o_mem_addr       = '0;
      o_mem_wdata      = '0;
      o_sp_dec         = 1'b0;
      o_pc_load        = 1'b0;
      o_pc_value       = '0;
      o_flush          = 1'b0;

      unique case (state_q)
         StIdle: begin
            // The stall is only honoured here; once started the sequence
            // runs to completion.
            if (pending && !i_stall_interrupt) begin
               state_d    = StPushHi;
               ret_d      = i_pc;
               flags_d    = i_flags;
               pend_clear = 1'b1;
            end
         end
         StPushHi: begin
            o_mem_write = 1'b1;
            o_mem_addr  = i_sp;
            o_mem_wdata = ret_q[PC_W-1:DATA_W];
            o_sp_dec    = 1'b1;
            state_d     = StPushLo;
         end
         StPushLo: begin
            o_mem_write = 1'b1;
            o_mem_addr  = i_sp;
            o_mem_wdata = ret_q[DATA_W-1:0];
            o_sp_dec    = 1'b1;
            state_d     = StPushFlags;
         end
         StPushFlags: begin
            o_mem_write = 1'b1;
            o_mem_addr  = i_sp;
            o_mem_wdata = DATA_W'(flags_q);
            o_sp_dec    = 1'b1;
            state_d     = StVecHi;
         end
         StVecHi: begin
            o_mem_read = 1'b1;
            o_mem_addr = VECTOR_ADDR;
            state_d    = StVecLo;
         end
         StVecLo: begin
            // Read data returning now belongs to the VecHi request.
            o_mem_read = 1'b1;
            o_mem_addr = VECTOR_ADDR + PC_W'(1);
            vec_hi_d   = i_mem_rdata;
            state_d    = StJump;
         end
         StJump: begin
            o_pc_load  = 1'b1;
            o_pc_value = {vec_hi_q, i_mem_rdata};
            o_flush    = 1'b1;
            state_d    = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (state_q != StIdle) begin
         o_interrupt_call = 1'b1;
         o_stall_fetch    = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= StIdle;
         ret_q    <= '0;
         flags_q  <= '0;
         vec_hi_q <= '0;
      end else begin
         state_q  <= state_d;
         ret_q    <= ret_d;
         flags_q  <= flags_d;
         vec_hi_q <= vec_hi_d;
      end
   end

endmodule
